// File: rtl/sram_ctrl_if.sv
// Master-side parallel bus between the UART bus master and the SRAM controller.
// Signals: cs (request, held until ack), we (1 = write), addr, wdata (master -> ctrl),
//          rdata (read data, valid from ack), ack (one-cycle completion pulse).
// Modports: master (bus master side), slave (controller side).
interface sram_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cs;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;

  modport master (output cs, output we, output addr, output wdata,
                  input  rdata, input ack);
  modport slave  (input  cs, input  we, input  addr, input  wdata,
                  output rdata, output ack);
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: accepts one request per cs assertion, sequences
// SETUP / ACCESS (WAIT_CYCLES) / HOLD (writes) on the SRAM strobes, then pulses ack.
// Ports:
//   i_clk, i_reset_n    : clock, asynchronous active-low reset
//   bus (slave)         : cs/we/addr/wdata in, rdata/ack out
//   o_sram_addr         : registered SRAM address
//   o_sram_data         : write data to pad cells
//   i_sram_data         : read data from pad cells
//   o_sram_data_oe      : pad output enable (1 = controller drives data pins)
//   o_sram_cs_n/we_n/oe_n : SRAM strobes, active low
// Optional: define SRAM_CTRL_COUNT_EN to add saturating o_rd_count / o_wr_count.
// WAIT_CYCLES legal range is 1..15.
module sram_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  sram_ctrl_if.slave            bus,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic                  o_sram_data_oe,
  output logic                  o_sram_cs_n,
  output logic                  o_sram_we_n,
  output logic                  o_sram_oe_n
`ifdef SRAM_CTRL_COUNT_EN
  ,
  output logic [15:0]           o_rd_count,
  output logic [15:0]           o_wr_count
`endif
);

  localparam int unsigned       CNT_W    = 4;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_ACK, S_RELEASE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_op, w_op_nxt;
  logic [ADDR_WIDTH-1:0] r_sram_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_sram_data, w_wdata_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_rdata_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_cs_n, w_cs_n_nxt;
  logic                  r_we_n, w_we_n_nxt;
  logic                  r_oe_n, w_oe_n_nxt;
  logic                  r_data_oe, w_data_oe_nxt;

  // State, latched request and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= 1'b0;
      r_sram_addr <= '0;
      r_sram_data <= '0;
      r_data      <= '0;
      r_ack       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_data_oe   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op        <= w_op_nxt;
      r_sram_addr <= w_addr_nxt;
      r_sram_data <= w_wdata_nxt;
      r_data      <= w_rdata_nxt;
      r_ack       <= w_ack_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_we_n      <= w_we_n_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_data_oe   <= w_data_oe_nxt;
    end
  end

  // Next state, then outputs decoded from the next state so strobes are
  // registered and valid for the whole cycle the state is occupied.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_op_nxt      = r_op;
    w_addr_nxt    = r_sram_addr;
    w_wdata_nxt   = r_sram_data;
    w_rdata_nxt   = r_data;
    w_ack_nxt     = 1'b0;
    w_cs_n_nxt    = 1'b1;
    w_we_n_nxt    = 1'b1;
    w_oe_n_nxt    = 1'b1;
    w_data_oe_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.cs) begin
          w_op_nxt    = bus.we;
          w_addr_nxt  = bus.addr;
          w_wdata_nxt = bus.wdata;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_cnt_nxt   = CNT_LOAD;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          if (r_op) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_rdata_nxt = i_sram_data;
            w_state_nxt = S_ACK;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD:    w_state_nxt = S_ACK;
      S_ACK:     w_state_nxt = S_RELEASE;
      S_RELEASE: if (!bus.cs) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase

    // Read never enables the pad driver, write never lowers oe_n.
    case (w_state_nxt)
      S_SETUP: begin
        w_cs_n_nxt = 1'b0;
        if (w_op_nxt) w_data_oe_nxt = 1'b1;
        else          w_oe_n_nxt    = 1'b0;
      end
      S_ACCESS: begin
        w_cs_n_nxt = 1'b0;
        if (w_op_nxt) begin
          w_we_n_nxt    = 1'b0;
          w_data_oe_nxt = 1'b1;
        end else begin
          w_oe_n_nxt    = 1'b0;
        end
      end
      S_HOLD: begin
        w_cs_n_nxt    = 1'b0;
        w_data_oe_nxt = 1'b1;
      end
      S_ACK:   w_ack_nxt = 1'b1;
      default: ;
    endcase
  end

`ifdef SRAM_CTRL_COUNT_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  // Saturating completion counters, updated together with the ack pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_ack_nxt) begin
      if (w_op_nxt && (r_wr_count != 16'hFFFF))
        r_wr_count <= r_wr_count + 16'd1;
      if (!w_op_nxt && (r_rd_count != 16'hFFFF))
        r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign o_rd_count = r_rd_count;
  assign o_wr_count = r_wr_count;
`endif

  assign bus.ack        = r_ack;
  assign bus.rdata      = r_data;
  assign o_sram_addr    = r_sram_addr;
  assign o_sram_data    = r_sram_data;
  assign o_sram_data_oe = r_data_oe;
  assign o_sram_cs_n    = r_cs_n;
  assign o_sram_we_n    = r_we_n;
  assign o_sram_oe_n    = r_oe_n;

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Asynchronous SRAM controller between the UART bus master's parallel bus (cs/we/addr/data, ack handshake) and the external 8-bit SRAM pins.
- Replaces the tied-high ack and direct strobe wiring with registered strobes, programmable access wait states, and write hold time.
- Drives the data-pad output-enable for the bidirectional pad cells.
- Latches each request at acceptance, sequences the SRAM, and returns read data with a one-cycle ack pulse.

Parameters:
ADDR_WIDTH, 16, bus/SRAM address width; upper pins beyond it are tied 0 at top level.
DATA_WIDTH, 8, data width.
WAIT_CYCLES, 2, cycles in ACCESS state (OE or WE low); legal range 1..15.

Ports:
i_clk  in  1  system clock (25 MHz).
i_reset_n  in  1  asynchronous active-low reset.
i_cs  in  1  bus request; held by master until o_ack.
i_we  in  1  1 = write, 0 = read; valid while i_cs.
i_addr  in  ADDR_WIDTH  bus address; valid while i_cs.
i_data  in  DATA_WIDTH  write data from master.
o_data  out  DATA_WIDTH  read data to master; valid from o_ack until next read ack.
o_ack  out  1  one-cycle completion pulse.
o_sram_addr  out  ADDR_WIDTH  registered SRAM address.
o_sram_data  out  DATA_WIDTH  data to pad cells.
i_sram_data  in  DATA_WIDTH  data from pad cells.
o_sram_data_oe  out  1  pad output enable (1 = FPGA drives bus).
o_sram_cs_n  out  1  SRAM chip select, active low.
o_sram_we_n  out  1  SRAM write enable, active low.
o_sram_oe_n  out  1  SRAM output enable, active low.

Behaviour:
- All outputs registered.
- Reset (async, any state): state=IDLE, o_ack=0, o_data=0, o_sram_addr=0, o_sram_data=0, o_sram_data_oe=0, cs_n=we_n=oe_n=1, wait counter=0.
- Never oe_n=0 and o_sram_data_oe=1 at the same time; never we_n=0 and oe_n=0 at the same time.
- States: IDLE, SETUP, ACCESS, HOLD, ACK, RELEASE. Edge E0 = edge at which IDLE samples i_cs=1.
- IDLE: strobes inactive. On i_cs=1, latch i_addr→o_sram_addr, i_we→op, i_data→o_sram_data; go to SETUP.
- SETUP, 1 cycle: cs_n=0.
  - Write: data_oe=1, we_n=1.
  - Read: oe_n=0, data_oe=0.
  - Counter loads WAIT_CYCLES-1.
- ACCESS, WAIT_CYCLES cycles: cs_n=0.
  - Write: we_n=0, data_oe=1.
  - Read: oe_n=0.
  - Counter decrements each cycle; leaves at counter==0.
  - Read: capture i_sram_data into o_data on the last ACCESS edge, then go to ACK.
  - Write: go to HOLD.
- HOLD (write only), 1 cycle: we_n=1, cs_n=0, data_oe=1, data unchanged.
- ACK, 1 cycle: o_ack=1, cs_n=we_n=oe_n=1, data_oe=0. Next state is RELEASE.
- RELEASE: wait while i_cs=1; go to IDLE when i_cs=0. Each request is served exactly once even if the master holds i_cs one extra cycle.
- Latency from E0 to o_ack high:
  - Read: WAIT_CYCLES+1 cycles (3 at default).
  - Write: WAIT_CYCLES+2 cycles (4 at default).
- Bus inputs changing after E0 are ignored until the next IDLE acceptance.
- Minimum back-to-back spacing: ACK, then RELEASE (≥1 cycle), then IDLE.
- Reset mid-write: we_n returns to 1 asynchronously. Partial SRAM write content is undefined; no ack is issued.

Optional Feature:
SRAM_CTRL_COUNT_EN
- Defined: adds outputs o_rd_count[15:0] and o_wr_count[15:0], reset 0. Each increments by 1 in the cycle o_ack is asserted for its op type and saturates at 0xFFFF (no wrap).
- Undefined: ports absent; no counter logic.

Test Plan:
- Reset: i_reset_n=0 asserted mid-ACCESS of a write → same cycle cs_n=we_n=oe_n=1, data_oe=0, o_ack=0; after release, state IDLE.
- Write 0xA5 to 0x1234, WAIT_CYCLES=2:
  - SRAM model sees addr 0x1234 stable with cs_n=0 for 4 cycles.
  - we_n low exactly 2 cycles; data 0xA5 driven from SETUP through HOLD.
  - o_ack pulses 4 cycles after E0.
- Read 0x1234 after that write → oe_n low 3 cycles, o_data=0xA5 when o_ack pulses 3 cycles after E0; data_oe stays 0 throughout.
- Master holds i_cs=1 for 5 cycles after o_ack → exactly one SRAM access and one ack; new access starts only after i_cs=0 then 1.
- WAIT_CYCLES=1 and 15, writes 0x00/0xFF to addresses 0x0000 and 0xFFFF → we_n low 1 and 15 cycles respectively; read-back matches; no address wrap.
- SRAM_CTRL_COUNT_EN defined: 3 writes then 2 reads → o_wr_count=3, o_rd_count=2; counter preloaded to 0xFFFF stays at 0xFFFF after another ack.
